// File: rtl/adc_capture_sequencer_pkg.sv
// Shared encodings and defaults for the ADC capture sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAL     = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_FAULT   = 3'd5
  } seq_state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_OVR     = 2'd1;
  localparam logic [1:0] FC_OVERRUN = 2'd2;

  localparam int DEF_DATA_W   = 10;
  localparam int DEF_CAL_LOG2 = 10;
  localparam int DEF_OVR_RUN  = 3;
  localparam int DEF_OUT_W    = 16;

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// Sample-in / corrected-sample-out stream bundle of the capture sequencer.
interface adc_capture_sequencer_if
  import adc_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W
);
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              adc_ovr;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output adc_data, adc_valid, adc_ovr, out_ready,
                  input  out_data, out_valid);
  modport slave  (input  adc_data, adc_valid, adc_ovr, out_ready,
                  output out_data, out_valid);
endinterface

// File: rtl/adc_capture_sequencer_dc_estimator.sv
// DC-offset estimator: averages 2^CAL_LOG2 samples, then holds the result.
module adc_dc_estimator
  import adc_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CAL_LOG2 = DEF_CAL_LOG2
) (
  input  logic              clk_adc,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic [DATA_W-1:0] offset_o,
  output logic              done_o
);
  localparam int ACC_W = DATA_W + CAL_LOG2;
  localparam logic [CAL_LOG2-1:0] CNT_ONE = CAL_LOG2'(1);

  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum_s;
  logic [CAL_LOG2-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]        offset_q, offset_d;
  logic signed [DATA_W-1:0] avg_s;
  logic                     take_s, last_s;

  assign take_s    = en_i & sample_valid_i;
  assign last_s    = take_s & (&cnt_q);
  assign acc_sum_s = acc_q + {{CAL_LOG2{sample_i[DATA_W-1]}}, sample_i};
  // Arithmetic shift floors toward -inf, e.g. -3.5 becomes -4.
  assign avg_s     = DATA_W'(acc_sum_s >>> CAL_LOG2);

  // Accumulate, count and capture the average on the final sample.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (last_s) begin
      acc_d    = '0;
      cnt_d    = '0;
      offset_d = avg_s;
    end else if (take_s) begin
      acc_d = acc_sum_s;
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      acc_d = acc_q;
    end
  end

  // Estimator state registers.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      offset_q <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
    end
  end

  assign offset_o = offset_q;
  assign done_o   = last_s;
endmodule

// File: rtl/adc_capture_sequencer.sv
// ADC capture sequencer: calibration, trigger arming, offset-corrected capture, faults.
// Optional ADC_SEQ_AUTO_REARM_EN: capture completion returns to ARMED instead of IDLE.
module adc_capture_sequencer
  import adc_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CAL_LOG2 = DEF_CAL_LOG2,
  parameter int OVR_RUN  = DEF_OVR_RUN,
  parameter int OUT_W    = DEF_OUT_W
) (
  input  logic                    clk_adc,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic                    cfg_abort,
  input  logic                    cfg_skip_cal,
  input  logic [15:0]             cfg_cap_len,
  input  logic                    trig,
  adc_capture_sequencer_if.slave  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic [1:0]              fault_code,
  output logic [2:0]              state_o,
  output logic [DATA_W-1:0]       dc_offset_o
);
  localparam int OVR_W = $clog2(OVR_RUN + 1);
  localparam logic [OVR_W-1:0] OVR_LAST = OVR_W'(OVR_RUN - 1);
  localparam logic [OVR_W-1:0] OVR_MAX  = OVR_W'(OVR_RUN);
  localparam logic [OVR_W-1:0] OVR_ONE  = OVR_W'(1);
  localparam logic [16:0]      CAP_ONE  = 17'd1;

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] adc_data_q;
  logic              adc_valid_q, adc_ovr_q, trig_q, trig_prev_q;
  logic [OVR_W-1:0]  ovr_cnt_q, ovr_cnt_d;
  logic [16:0]       cap_len_q, cap_len_d, cap_cnt_q, cap_cnt_d, cap_next_s;
  logic [OUT_W-1:0]  out_data_q, out_data_d, corr_ext_s;
  logic              out_valid_q, out_valid_d, done_q, done_d;
  logic              busy_q, busy_d, fault_q, fault_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic signed [DATA_W:0] corr_s;
  logic [DATA_W-1:0] dc_offset_s;
  logic              est_clear_s, est_en_s, est_done_s;
  logic              xfer_s, ovr_trip_s, fault_in_run_s;

  assign xfer_s         = out_valid_q & bus.out_ready;
  assign ovr_trip_s     = adc_valid_q & adc_ovr_q & (ovr_cnt_q >= OVR_LAST);
  assign fault_in_run_s = ovr_trip_s & ((state_q == ST_CAL) || (state_q == ST_CAPTURE));
  assign est_clear_s    = cfg_abort | ((state_q == ST_IDLE) & cfg_start);
  assign est_en_s       = (state_q == ST_CAL) & ~cfg_abort & ~fault_in_run_s;
  // One extra bit keeps the difference of two DATA_W values exact.
  assign corr_s         = {adc_data_q[DATA_W-1], adc_data_q} - {dc_offset_s[DATA_W-1], dc_offset_s};
  assign corr_ext_s     = {{(OUT_W-DATA_W-1){corr_s[DATA_W]}}, corr_s};
  assign cap_next_s     = cap_cnt_q + CAP_ONE;

  adc_dc_estimator #(.DATA_W(DATA_W), .CAL_LOG2(CAL_LOG2)) u_dc_est (
    .clk_adc        (clk_adc),
    .rst_n          (rst_n),
    .clear_i        (est_clear_s),
    .en_i           (est_en_s),
    .sample_valid_i (adc_valid_q),
    .sample_i       (adc_data_q),
    .offset_o       (dc_offset_s),
    .done_o         (est_done_s)
  );

  // Consecutive-overrange counter; idle cycles leave it untouched.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (cfg_abort) begin
      ovr_cnt_d = '0;
    end else if (adc_valid_q && adc_ovr_q) begin
      ovr_cnt_d = (ovr_cnt_q == OVR_MAX) ? ovr_cnt_q : ovr_cnt_q + OVR_ONE;
    end else if (adc_valid_q) begin
      ovr_cnt_d = '0;
    end else begin
      ovr_cnt_d = ovr_cnt_q;
    end
  end

  // Sequencer next state and output register; abort beats fault beats normal flow.
  always_comb begin
    state_d      = state_q;
    cap_len_d    = cap_len_q;
    cap_cnt_d    = cap_cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q & ~xfer_s;
    done_d       = 1'b0;
    fault_code_d = fault_code_q;
    if (cfg_abort) begin
      state_d      = ST_IDLE;
      out_valid_d  = 1'b0;
      cap_cnt_d    = '0;
      fault_code_d = FC_NONE;
    end else if (fault_in_run_s) begin
      state_d      = ST_FAULT;
      out_valid_d  = 1'b0;
      fault_code_d = FC_OVR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            cap_len_d = (cfg_cap_len == 16'd0) ? 17'h1_0000 : {1'b0, cfg_cap_len};
            state_d   = cfg_skip_cal ? ST_ARMED : ST_CAL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CAL: begin
          if (est_done_s) state_d = ST_ARMED;
          else            state_d = ST_CAL;
        end
        ST_ARMED: begin
          if (trig_q && !trig_prev_q) begin
            state_d   = ST_CAPTURE;
            cap_cnt_d = '0;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (adc_valid_q && out_valid_q && !bus.out_ready) begin
            state_d      = ST_FAULT;
            out_valid_d  = 1'b0;
            fault_code_d = FC_OVERRUN;
          end else if (adc_valid_q) begin
            out_data_d  = corr_ext_s;
            out_valid_d = 1'b1;
            cap_cnt_d   = cap_next_s;
            state_d     = (cap_next_s == cap_len_q) ? ST_DRAIN : ST_CAPTURE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
        ST_DRAIN: begin
          if (xfer_s) begin
            done_d = 1'b1;
`ifdef ADC_SEQ_AUTO_REARM_EN
            state_d = ST_ARMED;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_FAULT: begin
          out_valid_d = 1'b0;
          state_d     = ST_FAULT;
        end
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
    busy_d  = (state_d != ST_IDLE);
    fault_d = (state_d == ST_FAULT);
  end

  // Input stage and all sequencer registers.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      adc_data_q   <= '0;
      adc_valid_q  <= 1'b0;
      adc_ovr_q    <= 1'b0;
      trig_q       <= 1'b0;
      trig_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      ovr_cnt_q    <= '0;
      cap_len_q    <= '0;
      cap_cnt_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      adc_data_q   <= bus.adc_data;
      adc_valid_q  <= bus.adc_valid;
      adc_ovr_q    <= bus.adc_ovr;
      trig_q       <= trig;
      trig_prev_q  <= trig_q;
      state_q      <= state_d;
      ovr_cnt_q    <= ovr_cnt_d;
      cap_len_q    <= cap_len_d;
      cap_cnt_q    <= cap_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign fault_code    = fault_code_q;
  assign state_o       = state_q;
  assign dc_offset_o   = dc_offset_s;
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed scoreboard bench for adc_capture_sequencer (CAL_LOG2 = 4).
module tb_adc_capture_sequencer;
  localparam int DATA_W   = 10;
  localparam int CAL_LOG2 = 4;
  localparam int OVR_RUN  = 3;
  localparam int OUT_W    = 16;

  logic              clk_adc = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start = 1'b0, cfg_abort = 1'b0, cfg_skip_cal = 1'b0, trig = 1'b0;
  logic [15:0]       cfg_cap_len = 16'd0;
  logic              busy, done, fault;
  logic [1:0]        fault_code;
  logic [2:0]        state_o;
  logic [DATA_W-1:0] dc_offset_o;

  adc_capture_sequencer_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  adc_capture_sequencer #(.DATA_W(DATA_W), .CAL_LOG2(CAL_LOG2), .OVR_RUN(OVR_RUN), .OUT_W(OUT_W)) dut (
    .clk_adc      (clk_adc),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_skip_cal (cfg_skip_cal),
    .cfg_cap_len  (cfg_cap_len),
    .trig         (trig),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code),
    .state_o      (state_o),
    .dc_offset_o  (dc_offset_o)
  );

  always #5 clk_adc = ~clk_adc;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int done_ref = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic ovr_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_adc);
      #1;
    end
  endtask

  task automatic smp(input logic [DATA_W-1:0] d, input logic ovr);
    bus.adc_data  = d;
    bus.adc_ovr   = ovr;
    bus.adc_valid = 1'b1;
    cyc(1);
    bus.adc_valid = 1'b0;
    bus.adc_ovr   = 1'b0;
  endtask

  task automatic start(input logic skip, input logic [15:0] len);
    cfg_start    = 1'b1;
    cfg_skip_cal = skip;
    cfg_cap_len  = len;
    cyc(1);
    cfg_start    = 1'b0;
    cfg_skip_cal = 1'b0;
  endtask

  task automatic fire();
    trig = 1'b1;
    cyc(3);
    trig = 1'b0;
    check("capture_entered", 32'(state_o), 32'd3);
  endtask

  task automatic abort();
    cfg_abort = 1'b1;
    cyc(1);
    cfg_abort = 1'b0;
  endtask

  // Monitor: every accepted output beat is popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clk_adc);
      if (rst_n) begin
        if (done) done_cnt++;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL out_unexpected: got %0h expected none", bus.out_data);
          end else begin
            check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    bus.adc_data  = '0;
    bus.adc_valid = 1'b0;
    bus.adc_ovr   = 1'b0;
    bus.out_ready = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_offset", 32'(dc_offset_o), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fault_code", 32'(fault_code), 32'd0);

    // Calibrate on +20, capture 25 -> 5.
    start(1'b0, 16'd4);
    check("cal_state", 32'(state_o), 32'd1);
    repeat (16) smp(10'd20, 1'b0);
    cyc(1);
    check("cal_armed", 32'(state_o), 32'd2);
    check("cal_offset", 32'(dc_offset_o), 32'd20);
    fire();
    repeat (4) begin
      exp_q.push_back(16'd5);
      smp(10'd25, 1'b0);
    end
    cyc(4);
    check("done_once", 32'(done_cnt), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // -3/-4 alternation floors to -4; input -4 -> 0.
    start(1'b0, 16'd1);
    for (int i = 0; i < 8; i++) begin
      smp(10'h3FD, 1'b0);
      smp(10'h3FC, 1'b0);
    end
    cyc(1);
    check("neg_offset", 32'(dc_offset_o), 32'h3FC);
    fire();
    exp_q.push_back(16'd0);
    smp(10'h3FC, 1'b0);
    cyc(4);
    check("neg_done", 32'(done_cnt), 32'd2);

    // Skip-cal start and one-cycle backpressure without loss.
    start(1'b1, 16'd3);
    check("skip_armed", 32'(state_o), 32'd2);
    check("skip_offset", 32'(dc_offset_o), 32'h3FC);
    fire();
    bus.out_ready = 1'b0;
    exp_q.push_back(16'd14);
    smp(10'd10, 1'b0);
    cyc(1);
    exp_q.push_back(16'd15);
    smp(10'd11, 1'b0);
    bus.out_ready = 1'b1;
    cyc(1);
    exp_q.push_back(16'd16);
    smp(10'd12, 1'b0);
    cyc(4);
    check("bp_done", 32'(done_cnt), 32'd3);
    check("bp_idle", 32'(state_o), 32'd0);

    // Output overrun.
    start(1'b1, 16'd4);
    fire();
    bus.out_ready = 1'b0;
    smp(10'd1, 1'b0);
    smp(10'd2, 1'b0);
    cyc(2);
    check("overrun_fault", 32'(fault), 32'd1);
    check("overrun_code", 32'(fault_code), 32'd2);
    check("overrun_state", 32'(state_o), 32'd5);
    bus.out_ready = 1'b1;
    abort();
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_fault", 32'(fault), 32'd0);
    check("abort_code", 32'(fault_code), 32'd0);

    // Broken overrange runs are harmless; three in a row fault.
    start(1'b1, 16'd16);
    fire();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(16'd4);
      smp(10'd0, ovr_pat[i]);
    end
    cyc(1);
    check("ovr_nofault", 32'(fault), 32'd0);
    exp_q.push_back(16'd4);
    smp(10'd0, 1'b1);
    exp_q.push_back(16'd4);
    smp(10'd0, 1'b1);
    smp(10'd0, 1'b1);
    cyc(2);
    check("ovr_code", 32'(fault_code), 32'd1);
    check("ovr_out_valid", 32'(bus.out_valid), 32'd0);
    check("ovr_state", 32'(state_o), 32'd5);
    abort();

    // Abort mid-CAL keeps the previous offset.
    start(1'b0, 16'd1);
    repeat (5) smp(10'd100, 1'b0);
    abort();
    cyc(1);
    check("cal_abort_state", 32'(state_o), 32'd0);
    check("cal_abort_offset", 32'(dc_offset_o), 32'h3FC);

    // Reset during capture: everything zero, no done.
    start(1'b1, 16'd4);
    fire();
    exp_q.push_back(16'd4);
    smp(10'd0, 1'b0);
    cyc(2);
    done_ref = done_cnt;
    rst_n = 1'b0;
    cyc(1);
    check("mid_rst_state", 32'(state_o), 32'd0);
    check("mid_rst_offset", 32'(dc_offset_o), 32'd0);
    check("mid_rst_out", 32'(bus.out_data), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    cyc(3);
    check("mid_rst_no_done", 32'(done_cnt), 32'(done_ref));

    // Completion behaviour with cap_len = 2.
    start(1'b1, 16'd2);
`ifdef ADC_SEQ_AUTO_REARM_EN
    for (int k = 0; k < 3; k++) begin
      fire();
      exp_q.push_back(16'(2 * k + 1));
      smp(10'(2 * k + 1), 1'b0);
      exp_q.push_back(16'(2 * k + 2));
      smp(10'(2 * k + 2), 1'b0);
      cyc(4);
      check("rearm_state", 32'(state_o), 32'd2);
    end
    check("rearm_done", 32'(done_cnt), 32'(done_ref + 3));
    abort();
`else
    fire();
    exp_q.push_back(16'd7);
    smp(10'd7, 1'b0);
    exp_q.push_back(16'd8);
    smp(10'd8, 1'b0);
    cyc(4);
    check("single_state", 32'(state_o), 32'd0);
    check("single_done", 32'(done_cnt), 32'(done_ref + 1));
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
